alu_op_sequencer: RTL and testbench

Command-side sequencer for the team's combinational 16-bit ALU (a, b, opcode, ci in; out, carryout out). It accepts operation requests over a valid/ready port and drives registered operands into the ALU. It captures the result, including two-beat carry-chained 32-bit operations, and returns it over a valid/ready response port. It sits between the bus/control logic and the ALU instance, which the parent instantiates.

---
 rtl/alu_op_sequencer_pkg.sv | 19 +
 rtl/alu_op_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: FSM state encoding,
// ALU opcode names and the default datapath width.
package alu_op_sequencer_pkg;

  localparam int DEFAULT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } seq_state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_1   = 2'b01;
  localparam logic [1:0] OP_2   = 2'b10;
  localparam logic [1:0] OP_3   = 2'b11;

endpackage

// File: rtl/alu_op_sequencer.sv
// Command-side sequencer for an external combinational W-bit ALU.
// Accepts one request at a time, drives registered operands into the ALU
// for one beat (narrow) or two carry-chained beats (wide), captures the
// result and holds it on the response port until it is consumed.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  input  logic [1:0]     req_op,
  input  logic           req_ci,
  input  logic           req_wide,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [1:0]     alu_opcode,
  output logic           alu_ci,
  input  logic [W-1:0]   alu_out,
  input  logic           alu_carryout,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*W-1:0] rsp_data,
  output logic           rsp_carry,
  output logic           busy
);

  seq_state_e     r_state;
  seq_state_e     w_nextState;

  logic [W-1:0]   r_aluA;
  logic [W-1:0]   r_aluB;
  logic [1:0]     r_aluOpcode;
  logic           r_aluCi;
  logic [W-1:0]   r_hiA;
  logic [W-1:0]   r_hiB;
  logic           r_wide;
  logic [2*W-1:0] r_rspData;
  logic           r_rspCarry;

  logic           w_reqReady;
  logic           w_rspValid;
  logic           w_busy;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: one beat in LO, a second in HI only for wide ops, then hold in RESP until consumed.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_nextState = LO;
      LO:      w_nextState = r_wide ? HI : RESP;
      HI:      w_nextState = RESP;
      RESP:    if (rsp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Handshake and status outputs decode the state register only, so no input reaches them combinationally.
  always_comb begin
    w_reqReady = (r_state == IDLE);
    w_rspValid = (r_state == RESP);
    w_busy     = (r_state != IDLE);
  end

  // Operand loading on entry to LO/HI and result capture at the end of each beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aluA      <= '0;
      r_aluB      <= '0;
      r_aluOpcode <= OP_ADD;
      r_aluCi     <= 1'b0;
      r_hiA       <= '0;
      r_hiB       <= '0;
      r_wide      <= 1'b0;
      r_rspData   <= '0;
      r_rspCarry  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_aluA      <= req_a[W-1:0];
            r_aluB      <= req_b[W-1:0];
            r_aluOpcode <= req_op;
            r_aluCi     <= req_ci;
            r_hiA       <= req_a[2*W-1:W];
            r_hiB       <= req_b[2*W-1:W];
            r_wide      <= req_wide;
          end
        end
        LO: begin
          r_rspData[W-1:0] <= alu_out;
          r_rspCarry       <= alu_carryout;
          if (r_wide) begin
            r_aluA  <= r_hiA;
            r_aluB  <= r_hiB;
            r_aluCi <= alu_carryout;
          end else begin
            r_rspData[2*W-1:W] <= '0;
          end
        end
        HI: begin
          r_rspData[2*W-1:W] <= alu_out;
          r_rspCarry         <= alu_carryout;
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready  = w_reqReady;
  assign rsp_valid  = w_rspValid;
  assign busy       = w_busy;
  assign alu_a      = r_aluA;
  assign alu_b      = r_aluB;
  assign alu_opcode = r_aluOpcode;
  assign alu_ci     = r_aluCi;
  assign rsp_data   = r_rspData;
  assign rsp_carry  = r_rspCarry;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a bench ALU closes the loop, a transaction-level
// model predicts every output each cycle, and directed scenarios pin exact
// values, latencies, backpressure, busy rejection and reset behaviour.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [1:0]  req_op;
  logic        req_ci;
  logic        req_wide;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_opcode;
  logic        alu_ci;
  logic [15:0] alu_out;
  logic        alu_carryout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_carry;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int rspMode = 0;
  logic rndBit = 1'b0;

  alu_op_sequencer #(.W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_ci(req_ci), .req_wide(req_wide),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_ci(alu_ci),
    .alu_out(alu_out), .alu_carryout(alu_carryout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Bench ALU: add, subtract, xor with carry pass-through, shift-left through carry.
  function automatic logic [16:0] benchAlu(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] op, input logic ci);
    logic [16:0] r;
    case (op)
      2'b00:   r = {1'b0, a} + {1'b0, b} + {16'd0, ci};
      2'b01:   r = {1'b0, a} + {1'b0, ~b} + {16'd0, ci};
      2'b10:   r = {ci, a ^ b};
      default: r = {a[15], a[14:0], ci};
    endcase
    return r;
  endfunction

  // Whole-request result {carry, data}: one beat, or two beats with the low carry feeding the high beat.
  function automatic logic [32:0] refOp(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op, input logic ci, input logic wide);
    logic [16:0] lo;
    logic [16:0] hi;
    lo = benchAlu(a[15:0], b[15:0], op, ci);
    if (!wide) return {lo[16], 16'd0, lo[15:0]};
    hi = benchAlu(a[31:16], b[31:16], op, lo[16]);
    return {hi[16], hi[15:0], lo[15:0]};
  endfunction

  assign {alu_carryout, alu_out} = benchAlu(alu_a, alu_b, alu_opcode, alu_ci);

  assign rsp_ready = (rspMode == 0) || ((rspMode == 1) && rndBit);

  // Random consumer readiness, refreshed away from the active edge.
  always @(negedge clk) rndBit <= 1'($urandom_range(0, 1));

  task automatic checkOutput(input string name, input logic [32:0] actual, input logic [32:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction model state.
  longint      cyc = 0;
  longint      hiDue = -1;
  longint      respDue = -1;
  logic        mBusy;
  logic        mRespValid;
  logic [31:0] mData;
  logic        mCarry;
  logic [15:0] mAluA;
  logic [15:0] mAluB;
  logic [1:0]  mAluOp;
  logic        mAluCi;
  logic [15:0] pHiA;
  logic [15:0] pHiB;
  logic        pHiCi;
  logic [32:0] pResult;

  wire [16:0] wLoBeat = benchAlu(req_a[15:0], req_b[15:0], req_op, req_ci);
  wire [32:0] wRef    = refOp(req_a, req_b, req_op, req_ci, req_wide);

  // Edge counter used to schedule when the model expects the high beat and the response.
  always @(posedge clk) cyc <= cyc + 1;

  // Model: accepted request is solved at once; operands and the response appear on their scheduled edges.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mBusy      <= 1'b0;
      mRespValid <= 1'b0;
      mData      <= '0;
      mCarry     <= 1'b0;
      mAluA      <= '0;
      mAluB      <= '0;
      mAluOp     <= 2'b00;
      mAluCi     <= 1'b0;
    end else if (!mBusy) begin
      if (req_valid) begin
        mBusy   <= 1'b1;
        mAluA   <= req_a[15:0];
        mAluB   <= req_b[15:0];
        mAluOp  <= req_op;
        mAluCi  <= req_ci;
        pHiA    <= req_a[31:16];
        pHiB    <= req_b[31:16];
        pHiCi   <= wLoBeat[16];
        pResult <= wRef;
        hiDue   <= req_wide ? cyc + 1 : -1;
        respDue <= cyc + (req_wide ? 2 : 1);
      end
    end else if (mRespValid) begin
      if (rsp_ready) begin
        mBusy      <= 1'b0;
        mRespValid <= 1'b0;
      end
    end else begin
      if (cyc == hiDue) begin
        mAluA  <= pHiA;
        mAluB  <= pHiB;
        mAluCi <= pHiCi;
      end
      if (cyc == respDue) begin
        mRespValid <= 1'b1;
        mData      <= pResult[31:0];
        mCarry     <= pResult[32];
      end
    end
  end

  // Every cycle compare the DUT against the model on the falling edge.
  always @(negedge clk) begin
    checkOutput("req_ready", req_ready, !mBusy);
    checkOutput("busy", busy, mBusy);
    checkOutput("rsp_valid", rsp_valid, mRespValid);
    checkOutput("alu_a", alu_a, mAluA);
    checkOutput("alu_b", alu_b, mAluB);
    checkOutput("alu_opcode", alu_opcode, mAluOp);
    checkOutput("alu_ci", alu_ci, mAluCi);
    if (mRespValid) begin
      checkOutput("rsp_data", rsp_data, mData);
      checkOutput("rsp_carry", rsp_carry, mCarry);
    end
  end

  // Present a request and hold it until the sequencer accepts it; returns just after the accept edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                               input logic ci, input logic wide);
    req_a = a; req_b = b; req_op = op; req_ci = ci; req_wide = wide;
    req_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (req_ready) break;
      @(negedge clk);
    end
    checkOutput("accept_wait", req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom; req_op = 2'($urandom_range(0, 3));
    req_ci = 1'($urandom_range(0, 1)); req_wide = 1'($urandom_range(0, 1));
  endtask

  // Count edges from the accept edge (inclusive) until rsp_valid is seen; returns on a falling edge.
  task automatic waitResponse(output int lat);
    lat = 1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rsp_valid) break;
      @(posedge clk);
      lat++;
    end
    checkOutput("rsp_wait", rsp_valid, 1'b1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic [31:0] ra;
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = 2'b00; req_ci = 1'b0; req_wide = 1'b0;
    rspMode = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_alu_a", alu_a, 16'h0);
    checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_rsp_data", rsp_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_req_ready", req_ready, 1'b1);

    checkOutput("model_narrow_add", refOp(32'h3, 32'h4, OP_ADD, 1'b1, 1'b0), 33'h0_0000_0008);
    checkOutput("model_wide_chain", refOp(32'h0000FFFF, 32'h1, OP_ADD, 1'b0, 1'b1), 33'h0_0001_0000);
    checkOutput("model_wide_ovf", refOp(32'hFFFFFFFF, 32'h1, OP_ADD, 1'b0, 1'b1), 33'h1_0000_0000);

    applyStimulus(32'h0000_0003, 32'h0000_0004, OP_ADD, 1'b1, 1'b0);
    waitResponse(lat);
    checkOutput("narrow_latency", lat, 2);
    checkOutput("narrow_data", rsp_data, 32'h0000_0008);
    checkOutput("narrow_carry", rsp_carry, 1'b0);

    applyStimulus(32'h0000_FFFF, 32'h0000_0001, OP_ADD, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("wide_lo_ci", alu_ci, 1'b0);
    checkOutput("wide_lo_a", alu_a, 16'hFFFF);
    @(negedge clk);
    checkOutput("wide_hi_ci", alu_ci, 1'b1);
    checkOutput("wide_hi_a", alu_a, 16'h0000);
    checkOutput("wide_hi_valid", rsp_valid, 1'b0);
    @(negedge clk);
    checkOutput("wide_valid", rsp_valid, 1'b1);
    checkOutput("wide_data", rsp_data, 32'h0001_0000);
    checkOutput("wide_carry", rsp_carry, 1'b0);

    @(negedge clk);
    rspMode = 2;
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0, 1'b1);
    waitResponse(lat);
    checkOutput("ovf_latency", lat, 3);
    checkOutput("ovf_data", rsp_data, 32'h0000_0000);
    checkOutput("ovf_carry", rsp_carry, 1'b1);
    req_a = 32'h0000_0010; req_b = 32'h0000_0020; req_op = OP_ADD; req_ci = 1'b0; req_wide = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", rsp_valid, 1'b1);
      checkOutput("bp_rsp_data", rsp_data, 32'h0000_0000);
      checkOutput("bp_rsp_carry", rsp_carry, 1'b1);
      checkOutput("bp_req_ready", req_ready, 1'b0);
    end
    rspMode = 0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_idle_ready", req_ready, 1'b1);
    checkOutput("bp_idle_valid", rsp_valid, 1'b0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    waitResponse(lat);
    checkOutput("bp_second_latency", lat, 2);
    checkOutput("bp_second_data", rsp_data, 32'h0000_0030);

    applyStimulus(32'h1234_5678, 32'h1111_2222, OP_1, 1'b1, 1'b1);
    req_a = 32'h0000_00AB; req_b = 32'h0000_0001; req_op = OP_2; req_ci = 1'b0; req_wide = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    checkOutput("busy_lo_req_ready", req_ready, 1'b0);
    checkOutput("busy_lo_alu_a", alu_a, 16'h5678);
    checkOutput("busy_lo_opcode", alu_opcode, OP_1);
    @(negedge clk);
    checkOutput("busy_hi_req_ready", req_ready, 1'b0);
    checkOutput("busy_hi_alu_a", alu_a, 16'h1234);
    @(negedge clk);
    checkOutput("busy_sub_data", rsp_data, 32'h0123_3456);
    checkOutput("busy_sub_carry", rsp_carry, 1'b1);
    for (int n = 0; n < 20; n++) begin
      if (req_ready) break;
      @(negedge clk);
    end
    checkOutput("busy_then_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    waitResponse(lat);
    checkOutput("busy_held_latency", lat, 2);
    checkOutput("busy_held_data", rsp_data, 32'h0000_00AA);
    checkOutput("busy_held_carry", rsp_carry, 1'b0);

    applyStimulus(32'hAAAA_5555, 32'h1111_1111, OP_ADD, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_alu_a", alu_a, 16'h0);
    checkOutput("midrst_alu_b", alu_b, 16'h0);
    checkOutput("midrst_alu_ci", alu_ci, 1'b0);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("midrst_rsp_data", rsp_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_no_rsp", rsp_valid, 1'b0);
    applyStimulus(32'h0000_1234, 32'h0000_0001, OP_ADD, 1'b0, 1'b0);
    waitResponse(lat);
    checkOutput("postrst_latency", lat, 2);
    checkOutput("postrst_data", rsp_data, 32'h0000_1235);

    rspMode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      case ($urandom_range(0, 3))
        0:       ra = 32'hFFFF_FFFF;
        1:       ra = 32'h0000_FFFF;
        default: ra = $urandom;
      endcase
      applyStimulus(ra, $urandom_range(0, 1) ? 32'h0000_0001 : $urandom,
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rspMode = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkOutput("drain_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
